// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if: request/response bundle between the execute stage and the
// M-extension unit. The pipeline side drives the request, the unit answers.
interface muldiv_iter_if #(
  parameter int DWIDTH = 32
);
  logic              start;
  logic [2:0]        MDFunc;
  logic [DWIDTH-1:0] A;
  logic [DWIDTH-1:0] B;
  logic              busy;
  logic              done;
  logic [DWIDTH-1:0] MDOut;

  modport master (
    output start, MDFunc, A, B,
    input  busy, done, MDOut
  );

  modport slave (
    input  start, MDFunc, A, B,
    output busy, done, MDOut
  );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: RV32M/RV64M multiply/divide execute unit.
// Multiplies and divide special cases (divide by zero, signed overflow) finish
// the cycle after acceptance; other divides run a radix-2 restoring divider
// for DWIDTH iterations followed by one sign-fix cycle.
module muldiv_iter #(
  parameter  int DWIDTH = 32,
  localparam int CWIDTH = $clog2(DWIDTH + 1)
) (
  input logic          clock,
  input logic          reset,
  muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_busy;
  logic                w_accept;

  logic [DWIDTH-1:0]   r_rem;
  logic [DWIDTH-1:0]   r_quo;
  logic [DWIDTH-1:0]   r_dvs;
  logic [DWIDTH-1:0]   r_out;
  logic [CWIDTH-1:0]   r_cnt;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_is_rem;
  logic                r_done;

  logic                w_a_sgn;
  logic                w_b_sgn;
  logic signed [2*DWIDTH-1:0] w_a_ext;
  logic signed [2*DWIDTH-1:0] w_b_ext;
  logic signed [2*DWIDTH-1:0] w_prod;
  logic [DWIDTH-1:0]   w_mul_res;

  logic                w_sdiv;
  logic                w_div0;
  logic                w_ovf;
  logic [DWIDTH-1:0]   w_spec_res;

  logic [DWIDTH:0]     w_shift;
  logic                w_fits;
  logic [DWIDTH-1:0]   w_sub;
  logic [DWIDTH-1:0]   w_fix_res;

  // Two's-complement negate when the flag is set (abs value and sign fix).
  function automatic logic [DWIDTH-1:0] f_cond_neg(input logic neg,
                                                   input logic [DWIDTH-1:0] x);
    return neg ? -x : x;
  endfunction

  // Multiply: extend each operand according to its signedness so that one
  // 2*DWIDTH product serves MUL, MULH, MULHSU and MULHU.
  assign w_a_sgn   = (bus.MDFunc == 3'b001) || (bus.MDFunc == 3'b010);
  assign w_b_sgn   = (bus.MDFunc == 3'b001);
  assign w_a_ext   = {{DWIDTH{w_a_sgn & bus.A[DWIDTH-1]}}, bus.A};
  assign w_b_ext   = {{DWIDTH{w_b_sgn & bus.B[DWIDTH-1]}}, bus.B};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (bus.MDFunc[1:0] == 2'b00) ? w_prod[DWIDTH-1:0]
                                                : w_prod[2*DWIDTH-1:DWIDTH];

  // Divide special cases are resolved without iterating.
  assign w_sdiv     = ~bus.MDFunc[0];
  assign w_div0     = (bus.B == '0);
  assign w_ovf      = w_sdiv && (bus.A == MOST_NEG) && (bus.B == '1);
  assign w_spec_res = w_div0 ? (bus.MDFunc[1] ? bus.A : '1)
                             : (bus.MDFunc[1] ? '0    : bus.A);

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  // The shifted remainder needs DWIDTH+1 bits; a successful difference is
  // always below the divisor, so its low DWIDTH bits are exact.
  assign w_shift = {r_rem, r_quo[DWIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[DWIDTH-1:0] - r_dvs;

  assign w_fix_res = r_is_rem ? f_cond_neg(r_neg_r, r_rem)
                              : f_cond_neg(r_neg_q, r_quo);

  assign w_accept  = bus.start && !w_busy;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.MDOut = r_out;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and busy: only a divide needing iteration leaves IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start && bus.MDFunc[2] && !w_div0 && !w_ovf) w_state_nxt = S_DIV;
      end
      S_DIV: begin
        w_busy = 1'b1;
        if (r_cnt == CWIDTH'(1)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_busy      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, divider iteration, result write and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_out    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_FIX) begin
        r_out  <= w_fix_res;
        r_done <= 1'b1;
      end else if (r_state == S_DIV) begin
        r_rem <= w_fits ? w_sub : w_shift[DWIDTH-1:0];
        r_quo <= {r_quo[DWIDTH-2:0], w_fits};
        r_cnt <= r_cnt - CWIDTH'(1);
      end else if (w_accept) begin
        if (!bus.MDFunc[2]) begin
          r_out  <= w_mul_res;
          r_done <= 1'b1;
        end else if (w_div0 || w_ovf) begin
          r_out  <= w_spec_res;
          r_done <= 1'b1;
        end else begin
          r_rem    <= '0;
          r_quo    <= f_cond_neg(w_sdiv & bus.A[DWIDTH-1], bus.A);
          r_dvs    <= f_cond_neg(w_sdiv & bus.B[DWIDTH-1], bus.B);
          r_neg_q  <= w_sdiv & (bus.A[DWIDTH-1] ^ bus.B[DWIDTH-1]);
          r_neg_r  <= w_sdiv & bus.A[DWIDTH-1];
          r_is_rem <= bus.MDFunc[1];
          r_cnt    <= CWIDTH'(DWIDTH);
        end
      end
    end
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised RV32M/RV64M execute unit implementing the full M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Multiplies complete in one registered cycle.
- Divides/remainders use an iterative radix-2 restoring divider under a small FSM, with a start/busy/done handshake to the pipeline stall logic.
- Sits in the execute stage beside the ALU; the decoder drives MDFunc from funct3.

Parameters:
- DWIDTH, 32, operand and result width in bits; must be even and >= 8.
- CWIDTH, $clog2(DWIDTH+1), width of the iteration counter (derived; not overridden).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- MDFunc  input  3  funct3 op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  input  DWIDTH  rs1 operand (dividend for divides).
- B  input  DWIDTH  rs2 operand (divisor for divides).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse; MDOut is valid in the same cycle.
- MDOut  output  DWIDTH  registered result; holds its value until the next done.

Behaviour:
- Reset: busy=0, done=0, MDOut=0, FSM=IDLE, counter=0, internal remainder/quotient registers 0. A reset asserted mid-division aborts the operation in that cycle; no done pulse is produced.
- Acceptance: start is accepted when start=1 and busy=0 at a clock edge; A, B and MDFunc are captured at that edge. Start while busy=1 is ignored, with no queuing.
- Multiply ops (MDFunc[2]=0):
  - The 2*DWIDTH product is computed combinationally from the inputs at acceptance.
  - MUL returns the low half. MULH, MULHSU and MULHU return the high half of signed*signed, signed*unsigned and unsigned*unsigned products respectively.
  - The result is registered into MDOut with done=1 on the next cycle (latency 1). busy stays 0, so back-to-back multiplies issue every cycle.
- Divide ops (MDFunc[2]=1), FSM IDLE -> DIV -> FIX -> IDLE:
  - Accept:
    - Signed ops (DIV, REM) latch |A| and |B|, plus the quotient sign (A[msb]^B[msb]) and the remainder sign (A[msb]).
    - Unsigned ops latch A and B as-is.
    - counter=DWIDTH. Enter DIV; busy=1.
  - DIV: each cycle, shift {rem,quo} left by one and trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quo LSB to 1. Decrement counter; leave DIV after DWIDTH cycles.
  - FIX: apply the sign correction (two's-complement negate of quotient/remainder as flagged). Write MDOut, pulse done, clear busy, return to IDLE.
  - Total latency from the accepting edge to done is DWIDTH+2 cycles (34 for DWIDTH=32). busy is high for DWIDTH+1 cycles.
  - A new start is accepted on the same edge on which done is asserted (busy=0 in that cycle).
- Special cases (resolved at acceptance, no iteration, latency 1 like multiply, busy stays 0):
  - Divide by zero (B=0): DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow (A=most-negative, B=-1, DIV/REM only): DIV returns A; REM returns 0.
- Operand changes after acceptance do not affect the result. MDOut changes only on done cycles and on reset.
- done never asserts without a preceding accepted start and never asserts twice per start.

Test Plan:
- DWIDTH=32, A=0xFFFFFFFE (-2), B=0x00000003, start with MUL/MULH/MULHSU/MULHU on consecutive cycles -> done on 4 consecutive cycles, MDOut = 0xFFFFFFFA, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000002; busy stays 0.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy high 33 cycles, done at cycle 34, MDOut=0xFFFFFFFD (-3); repeat with REM -> 0xFFFFFFFF (-1); DIVU same operands -> 0x7FFFFFFC; REMU -> 0x00000001.
- Divide by zero, A=0x12345678, B=0: DIVU -> 0xFFFFFFFF at cycle 1; REM -> 0x12345678 at cycle 1; busy never rises.
- Overflow A=0x80000000, B=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0x00000000, both at latency 1.
- During a DIV (100/7), toggle start with MUL ops and change A/B every cycle -> starts ignored, single done at cycle 34, MDOut=14; then REM 100/7 issued on the done cycle -> second done 34 cycles later with MDOut=2.
- Assert reset at cycle 10 of a DIVU -> busy=0, MDOut=0 the next cycle, no done pulse; a fresh DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF. Repeat the random signed/unsigned sweep at DWIDTH=16 and 64 against the reference model.
